// File: rtl/obi_wishbone_arbiter_if.sv
// obi_wishbone_arbiter_if
//   Bundles the two OBI requester ports (instruction fetch, load/store) and
//   the single Wishbone classic master bus shared between them.
//
//   modport master : the arbiter side. It consumes OBI requests, produces
//                    OBI grant/response, drives the Wishbone master signals
//                    and consumes Wishbone ack/read data.
//   modport slave  : the environment side. It holds the OBI requesters and
//                    the Wishbone slave.
interface obi_wishbone_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction OBI port
  logic              instr_req_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [DATA_W-1:0] instr_rdata_o;
  logic              instr_err_o;

  // data OBI port
  logic              data_req_i;
  logic              data_we_i;
  logic [3:0]        data_be_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_err_o;

  // Wishbone classic master bus
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [3:0]        wb_sel_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [DATA_W-1:0] wb_data_i;
  logic              wb_ack_i;

  modport master (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
    input  wb_data_i, wb_ack_i
  );

  modport slave (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
    output wb_data_i, wb_ack_i
  );
endinterface

// File: rtl/obi_wishbone_arbiter.sv
// obi_wishbone_arbiter
//   Shares one Wishbone classic master bus between the CV32E40X instruction
//   and data OBI ports. One transaction in flight at a time, round-robin
//   between the two requesters, and a bus timeout that converts a stalled
//   slave into an OBI error response.
//
//   Parameters:
//     ADDR_W          address width (OBI and Wishbone)
//     DATA_W          data width, must be 32 (byte enables are 4 bits)
//     TIMEOUT_CYCLES  max cycles in a bus cycle without ack; 0 disables
//
//   Ports:
//     clk_i   core clock
//     rst_ni  asynchronous active-low reset
//     bus     obi_wishbone_arbiter_if.master: both OBI ports + Wishbone bus
//
//   Port index 0 is the instruction port, index 1 the data port.
module obi_wishbone_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  obi_wishbone_arbiter_if.master  bus
);

  localparam int NUM_PORTS = 2;
  // The counter only has to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUS  = 1'b1;

  logic [0:0]                         state;
  logic                               last_grant;
  logic                               owner;
  logic                               winner;
  logic                               grant;
  logic [NUM_PORTS-1:0]               req;
  logic [NUM_PORTS-1:0]               gnt;
  logic [CNT_W-1:0]                   cnt;
  logic                               timeout_hit;
  logic                               done;

  logic                               wb_we;
  logic [3:0]                         wb_sel;
  logic [ADDR_W-1:0]                  wb_addr;
  logic [DATA_W-1:0]                  wb_wdata;

  logic [DATA_W-1:0]                  rsp_data;
  logic                               rsp_err;
  logic [NUM_PORTS-1:0]               rsp_fire;
  logic [NUM_PORTS-1:0]               rvalid;
  logic [NUM_PORTS-1:0]               err;
  logic [NUM_PORTS-1:0][DATA_W-1:0]   rdata;

  assign req = {bus.data_req_i, bus.instr_req_i};

  // Round robin: on a tie the port that did not win last time goes first.
  always_comb begin
    winner = PORT_INSTR;
    if (&req) winner = ~last_grant;
    else      winner = req[PORT_DATA];
  end

  // Grant is combinational; qualifying it with rst_ni keeps it low for the
  // whole reset even if a requester holds req high.
  assign grant            = rst_ni && (state == ST_IDLE) && (|req);
  assign gnt[PORT_INSTR]  = grant && (winner == PORT_INSTR);
  assign gnt[PORT_DATA]   = grant && (winner == PORT_DATA);

  // The counter is 0 in the first bus cycle, so hitting TIMEOUT_CYCLES-1
  // here means this is the TIMEOUT_CYCLES-th cycle without an ack.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

  // An ack seen in IDLE never gets here: done needs the BUS state.
  assign done = (state == ST_BUS) && (bus.wb_ack_i || timeout_hit);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      last_grant <= PORT_DATA;
      owner      <= PORT_INSTR;
      cnt        <= '0;
      wb_we      <= 1'b0;
      wb_sel     <= 4'h0;
      wb_addr    <= '0;
      wb_wdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (grant) begin
            state      <= ST_BUS;
            owner      <= winner;
            last_grant <= winner;
            if (winner == PORT_DATA) begin
              wb_we    <= bus.data_we_i;
              wb_sel   <= bus.data_be_i;
              wb_addr  <= bus.data_addr_i;
              wb_wdata <= bus.data_wdata_i;
            end else begin
              // fetches are always full-word reads
              wb_we    <= 1'b0;
              wb_sel   <= 4'hF;
              wb_addr  <= bus.instr_addr_i;
              wb_wdata <= '0;
            end
          end
        end
        ST_BUS: begin
          if (done) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A timeout looks like an ack carrying zero data plus the error flag.
  assign rsp_data = bus.wb_ack_i ? bus.wb_data_i : '0;
  assign rsp_err  = ~bus.wb_ack_i;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
      assign rsp_fire[p] = done && (owner == 1'(p));

      obi_wishbone_arbiter_rsp #(
        .DATA_W (DATA_W)
      ) u_rsp (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .fire    (rsp_fire[p]),
        .err_in  (rsp_err),
        .data_in (rsp_data),
        .rvalid  (rvalid[p]),
        .rdata   (rdata[p]),
        .err     (err[p])
      );
    end
  endgenerate

  // cyc/stb come straight from the state flop, so reset drops them at once.
  assign bus.wb_cyc_o       = (state == ST_BUS);
  assign bus.wb_stb_o       = (state == ST_BUS);
  assign bus.wb_we_o        = wb_we;
  assign bus.wb_sel_o       = wb_sel;
  assign bus.wb_addr_o      = wb_addr;
  assign bus.wb_data_o      = wb_wdata;

  assign bus.instr_gnt_o    = gnt[PORT_INSTR];
  assign bus.instr_rvalid_o = rvalid[PORT_INSTR];
  assign bus.instr_rdata_o  = rdata[PORT_INSTR];
  assign bus.instr_err_o    = err[PORT_INSTR];

  assign bus.data_gnt_o     = gnt[PORT_DATA];
  assign bus.data_rvalid_o  = rvalid[PORT_DATA];
  assign bus.data_rdata_o   = rdata[PORT_DATA];
  assign bus.data_err_o     = err[PORT_DATA];

endmodule

// obi_wishbone_arbiter_rsp
//   Per-port OBI response register. rvalid is a one-cycle pulse; rdata and
//   err hold until the next response to the same port.
//
//   Ports:
//     clk_i, rst_ni  clock, async active-low reset
//     fire           this port owns the finishing bus cycle
//     err_in         response is a timeout
//     data_in        read data to capture
//     rvalid         OBI response valid pulse
//     rdata, err     held response data / error flag
module obi_wishbone_arbiter_rsp #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fire,
  input  logic              err_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= fire;
      if (fire) begin
        rdata <= data_in;
        err   <= err_in;
      end
    end
  end

endmodule

// File: doc/obi_wishbone_arbiter.md
# obi_wishbone_arbiter

Shares the single Wishbone classic master bus of `processorci_top` between the CV32E40X instruction and data OBI ports. It runs one transaction at a time, arbitrates round-robin between the two OBI requesters, and converts each OBI request/grant/rvalid handshake into a Wishbone cyc/stb/ack cycle. A bus timeout turns a stalled slave into an OBI error response.

## Interface
- `ADDR_W`, 32: address width, both OBI ports and Wishbone.
- `DATA_W`, 32: data width; must be 32.
- `TIMEOUT_CYCLES`, 1024: maximum cycles in BUS without `wb_ack_i`. 0 disables the timeout.

Ports:
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset. Asynchronous assertion, active-low.
- `instr_req_i`  in  1  instruction fetch request.
- `instr_addr_i`  in  ADDR_W  fetch address.
- `instr_gnt_o`  out  1  fetch request accepted.
- `instr_rvalid_o`  out  1  fetch response valid.
- `instr_rdata_o`  out  DATA_W  fetch data.
- `instr_err_o`  out  1  fetch timed out; qualified by `instr_rvalid_o`.
- `data_req_i`  in  1  load/store request.
- `data_we_i`  in  1  1 = store.
- `data_be_i`  in  4  byte enables.
- `data_addr_i`  in  ADDR_W  data address.
- `data_wdata_i`  in  DATA_W  store data.
- `data_gnt_o`  out  1  data request accepted.
- `data_rvalid_o`  out  1  data response valid.
- `data_rdata_o`  out  DATA_W  load data.
- `data_err_o`  out  1  data access timed out; qualified by `data_rvalid_o`.
- `wb_cyc_o`, `wb_stb_o`  out  1  Wishbone cycle and strobe (always equal).
- `wb_we_o`  out  1  Wishbone write enable.
- `wb_sel_o`  out  4  Wishbone byte select.
- `wb_addr_o`  out  ADDR_W  Wishbone address.
- `wb_data_o`  out  DATA_W  Wishbone write data.
- `wb_data_i`  in  DATA_W  Wishbone read data.
- `wb_ack_i`  in  1  Wishbone acknowledge.

## Operation
- States are IDLE and BUS. Reset puts the block in IDLE.
- **Reset values:**
  - `last_grant` = DATA.
  - All outputs 0.
  - Timeout counter 0.
- **IDLE:**
  - Winner is the only requester, or, if both request, the port not equal to `last_grant`.
  - The winner's `*_gnt_o` = 1 combinationally in the same cycle; the other port's gnt = 0.
  - On grant, latch address, we, sel and wdata, set `last_grant` to the winner, and go to BUS.
  - Instruction port: we = 0, sel = 4'hF. Data port: `data_we_i` and `data_be_i` are passed unmodified.
- **BUS:**
  - `wb_cyc_o` = `wb_stb_o` = 1 (registered) and the latched fields are driven.
  - Both gnt outputs are 0.
  - The counter increments each cycle.
  - On `wb_ack_i`:
    - drop cyc/stb next cycle;
    - register `wb_data_i` into the owner's rdata;
    - pulse the owner's rvalid for 1 cycle with err = 0;
    - return to IDLE, and clear the counter.
- **Timeout:** if the counter reaches `TIMEOUT_CYCLES` without an ack, behave exactly as an ack, except rdata = 0 and err = 1.
- rdata holds its value until the next response to the same port.
- The rvalid pulse and a new grant may occur in the same cycle, since the block is back in IDLE.
- A `wb_ack_i` seen while in IDLE is ignored.
- Requests are not dropped: OBI requires req to stay high until gnt.
- Asserting `rst_ni` low mid-transaction aborts immediately:
  - cyc/stb drop asynchronously;
  - no rvalid is issued;
  - `last_grant` returns to DATA.

## Timing
- Request at cycle N (block idle): gnt at N; cyc/stb from N+1.
- Ack at cycle M ≥ N+1: rvalid and rdata at M+1; cyc/stb low at M+1; earliest next gnt at M+1.
- Zero-wait slave (ack at N+1): one transaction every 2 cycles, rvalid at N+2.
- Timeout: err rvalid at N+1+TIMEOUT_CYCLES.
- At most one outstanding transaction in total; no pipelining.

## Test plan
- **Instruction only.** `instr_req_i` = 1, addr 0x100; slave acks 1 cycle after stb with 0x00000013.
  - gnt at N.
  - sel = F, we = 0, addr 0x100 at N+1.
  - `instr_rvalid_o` at N+2 with rdata 0x00000013, err 0.
- **Data store.** `data_req_i` with we = 1, be = 4'b0011, addr 0x2000, wdata 0xDEADBEEF.
  - Wishbone shows we = 1, sel = 3, data 0xDEADBEEF.
  - `data_rvalid_o` 1 cycle after ack.
- **Contention.** Both ports request continuously from reset.
  - Grants go instr, data, instr, data.
  - Each rvalid goes only to its owner; no grant while in BUS.
- **Wait states.** Ack delayed 5 cycles.
  - cyc/stb held high and fields stable for 5 cycles.
  - rvalid exactly 1 cycle after ack.
- **Timeout.** `TIMEOUT_CYCLES` = 8, slave never acks.
  - `data_rvalid_o` = 1, `data_err_o` = 1, rdata 0 at grant + 9.
  - Next request is granted normally.
- **Reset mid-BUS.** Assert `rst_ni` low while cyc = 1.
  - cyc/stb/gnt/rvalid go to 0 without a clock edge.
  - After release, a tied request goes to instr first.
